// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, in-order imem requests, response FIFO, decode handshake.
// Redirects flush the FIFO and drop responses still in flight for the old path.
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REDIRECT_VALID,
    input  logic [ADDR_WIDTH-1:0] REDIRECT_PC,
    output logic                  IMEM_REQ,
    output logic [ADDR_WIDTH-1:0] IMEM_ADDR,
    input  logic                  IMEM_GNT,
    input  logic                  IMEM_RVALID,
    input  logic [31:0]           IMEM_RDATA,
    output logic                  INSTR_VALID,
    input  logic                  INSTR_READY,
    output logic [31:0]           INSTR,
    output logic [ADDR_WIDTH-1:0] INSTR_PC,
    output logic [6:0]            INSTRUCTION_FORMAT
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW:0]   DEPTH_EXT = (CW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PTR  = PW'(FIFO_DEPTH - 1);

    typedef enum logic {FETCH, FLUSH} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] pc, resp_pc, redirect_tgt;
    logic [CW-1:0]         count, outstanding, discard, discard_nxt;
    logic [CW-1:0]         inflight_left;
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [31:0]           fifo_instr [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_pc    [FIFO_DEPTH];
    logic                  req, gnt_fire, rsp, push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign redirect_tgt = {REDIRECT_PC[ADDR_WIDTH-1:2], 2'b00};

    // Credit: buffered plus in-flight words may never exceed the FIFO size.
    assign req = !RST && !REDIRECT_VALID && (state == FETCH)
              && (({1'b0, count} + {1'b0, outstanding}) < DEPTH_EXT);

    assign gnt_fire      = req && IMEM_GNT;
    assign rsp           = IMEM_RVALID && (outstanding != '0);
    assign push          = rsp && (state == FETCH) && !REDIRECT_VALID;
    assign pop           = INSTR_VALID && INSTR_READY && !REDIRECT_VALID;
    assign inflight_left = outstanding - CW'(rsp);

    assign IMEM_REQ           = req;
    assign IMEM_ADDR          = pc;
    assign INSTR_VALID        = (count != '0);
    assign INSTR              = fifo_instr[rd_ptr];
    assign INSTR_PC           = fifo_pc[rd_ptr];
    assign INSTRUCTION_FORMAT = INSTR[6:0];

    always_comb begin
        state_nxt   = state;
        discard_nxt = discard;
        if (REDIRECT_VALID) begin
            if (inflight_left == '0) begin
                state_nxt = FETCH;
            end else begin
                state_nxt   = FLUSH;
                discard_nxt = inflight_left;
            end
        end else if (state == FLUSH && rsp) begin
            discard_nxt = discard - CW'(1);
            if (discard == CW'(1)) state_nxt = FETCH;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
        end else begin
            state       <= state_nxt;
            discard     <= discard_nxt;
            outstanding <= outstanding + CW'(gnt_fire) - CW'(rsp);
            if (REDIRECT_VALID) begin
                pc      <= redirect_tgt;
                resp_pc <= redirect_tgt;
                count   <= '0;
                rd_ptr  <= '0;
                wr_ptr  <= '0;
            end else begin
                if (gnt_fire) pc <= pc + ADDR_WIDTH'(4);
                if (push) begin
                    fifo_instr[wr_ptr] <= IMEM_RDATA;
                    fifo_pc[wr_ptr]    <= resp_pc;
                    wr_ptr             <= ptr_inc(wr_ptr);
                    resp_pc            <= resp_pc + ADDR_WIDTH'(4);
                end
                if (pop) rd_ptr <= ptr_inc(rd_ptr);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // A response with nothing outstanding is a memory-side protocol error.
    a_rvalid_has_owner: assert property (
        @(posedge CLK) disable iff (RST) IMEM_RVALID |-> (outstanding != '0)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory model, expected-PC scoreboard
// and a decoupled monitor comparing every word taken by decode.
module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        REDIRECT_VALID;
    logic [31:0] REDIRECT_PC;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_GNT;
    logic        IMEM_RVALID;
    logic [31:0] IMEM_RDATA;
    logic        INSTR_VALID;
    logic        INSTR_READY;
    logic [31:0] INSTR;
    logic [31:0] INSTR_PC;
    logic [6:0]  INSTRUCTION_FORMAT;

    instr_fetch_unit dut (
        .CLK               (CLK),
        .RST               (RST),
        .REDIRECT_VALID    (REDIRECT_VALID),
        .REDIRECT_PC       (REDIRECT_PC),
        .IMEM_REQ          (IMEM_REQ),
        .IMEM_ADDR         (IMEM_ADDR),
        .IMEM_GNT          (IMEM_GNT),
        .IMEM_RVALID       (IMEM_RVALID),
        .IMEM_RDATA        (IMEM_RDATA),
        .INSTR_VALID       (INSTR_VALID),
        .INSTR_READY       (INSTR_READY),
        .INSTR             (INSTR),
        .INSTR_PC          (INSTR_PC),
        .INSTRUCTION_FORMAT(INSTRUCTION_FORMAT)
    );

    always #5 CLK = ~CLK;

    int          n_cmp  = 0;
    int          n_err  = 0;
    int          n_pop  = 0;
    int          n_fire = 0;
    logic [31:0] exp_q  [$];
    logic [31:0] pend_q [$];
    logic [31:0] ref_addr;
    logic        s_req, s_ivalid;
    logic [31:0] s_addr, s_ipc;
    logic [31:0] mon_exp, mon_word;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hC0FF_EE13;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic restart_stream(input logic [31:0] base);
        exp_q.delete();
        for (int k = 0; k < 512; k++) exp_q.push_back(base + 32'(4 * k));
        ref_addr = base;
    endtask

    task automatic tick(input bit gnt, input bit rv_en, input bit rdy,
                        input bit redir = 1'b0,
                        input logic [31:0] tgt = 32'h0);
        bit fire;
        @(negedge CLK);
        IMEM_GNT       = gnt;
        INSTR_READY    = rdy;
        REDIRECT_VALID = redir;
        REDIRECT_PC    = tgt;
        if (rv_en && pend_q.size() > 0) begin
            IMEM_RVALID = 1'b1;
            IMEM_RDATA  = word_at(pend_q[0]);
        end else begin
            IMEM_RVALID = 1'b0;
            IMEM_RDATA  = 32'h0;
        end
        #1;
        s_req    = IMEM_REQ;
        s_addr   = IMEM_ADDR;
        s_ivalid = INSTR_VALID;
        s_ipc    = INSTR_PC;
        fire     = IMEM_REQ && gnt;
        if (fire) begin
            chk("imem_addr", IMEM_ADDR, ref_addr);
            ref_addr = ref_addr + 32'd4;
            n_fire++;
        end
        if (redir) restart_stream({tgt[31:2], 2'b00});
        @(posedge CLK);
        if (IMEM_RVALID) void'(pend_q.pop_front());
        if (fire) pend_q.push_back(s_addr);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("rst_imem_req", 32'(IMEM_REQ), 32'h0);
        chk("rst_instr_valid", 32'(INSTR_VALID), 32'h0);
        chk("rst_instr", INSTR, 32'h0);
        chk("rst_instr_pc", INSTR_PC, 32'h0);
        IMEM_GNT       = 1'b0;
        IMEM_RVALID    = 1'b0;
        IMEM_RDATA     = 32'h0;
        INSTR_READY    = 1'b0;
        REDIRECT_VALID = 1'b0;
        REDIRECT_PC    = 32'h0;
        pend_q.delete();
        restart_stream(32'h0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    always @(negedge CLK) begin
        #2;
        if (!RST && INSTR_VALID && INSTR_READY && !REDIRECT_VALID) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL scoreboard_empty: got pc %h expected none",
                         INSTR_PC);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_word = word_at(mon_exp);
                chk("instr_pc", INSTR_PC, mon_exp);
                chk("instr", INSTR, mon_word);
                chk("opcode", {25'h0, INSTRUCTION_FORMAT},
                    {25'h0, mon_word[6:0]});
            end
        end
    end

    initial begin
        int p0, f0;
        bit seen;
        RST            = 1'b1;
        REDIRECT_VALID = 1'b0;
        REDIRECT_PC    = 32'h0;
        IMEM_GNT       = 1'b0;
        IMEM_RVALID    = 1'b0;
        IMEM_RDATA     = 32'h0;
        INSTR_READY    = 1'b0;
        restart_stream(32'h0);

        // 1: streaming; credit ignores same-cycle pop, so 2 of every 3 cycles pop
        do_reset();
        p0 = n_pop;
        tick(1, 1, 1);
        tick(1, 1, 1);
        tick(1, 1, 1);
        chk("first_word_valid", 32'(s_ivalid), 32'h1);
        chk("first_word_pc", s_ipc, 32'h0);
        repeat (15) tick(1, 1, 1);
        chk("stream_pops", 32'(n_pop - p0), 32'd11);

        // 2: decode stalled, credit caps requests at the FIFO depth
        do_reset();
        f0 = n_fire;
        repeat (10) tick(1, 1, 0);
        chk("stall_fires", 32'(n_fire - f0), 32'd2);
        chk("stall_req_low", 32'(s_req), 32'h0);
        chk("stall_valid", 32'(s_ivalid), 32'h1);
        chk("stall_head_pc", s_ipc, 32'h0);
        repeat (6) tick(1, 1, 1);

        // 3: redirect with two requests in flight
        do_reset();
        repeat (3) tick(1, 0, 0);
        tick(1, 0, 0, 1, 32'h103);
        chk("redir_req_low", 32'(s_req), 32'h0);
        tick(1, 1, 1);
        chk("flush1_req", 32'(s_req), 32'h0);
        chk("flush1_valid", 32'(s_ivalid), 32'h0);
        tick(1, 1, 1);
        chk("flush2_req", 32'(s_req), 32'h0);
        tick(1, 1, 1);
        chk("refetch_req", 32'(s_req), 32'h1);
        chk("refetch_addr", s_addr, 32'h100);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick(1, 1, 1);
            if (s_ivalid) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL refetch_timeout: got no INSTR_VALID expected one");
        end else begin
            chk("refetch_instr_pc", s_ipc, 32'h100);
        end
        repeat (6) tick(1, 1, 1);

        // 4: redirect coinciding with response and pop, one in flight
        do_reset();
        tick(1, 0, 0);
        tick(0, 1, 0);
        tick(1, 0, 0);
        tick(1, 1, 1, 1, 32'h200);
        chk("t4_redir_valid_before", 32'(s_ivalid), 32'h1);
        chk("t4_redir_req", 32'(s_req), 32'h0);
        tick(1, 1, 1);
        chk("t4_fifo_empty", 32'(s_ivalid), 32'h0);
        chk("t4_req", 32'(s_req), 32'h1);
        chk("t4_addr", s_addr, 32'h200);
        repeat (8) tick(1, 1, 1);

        // 5: reset while data is buffered and a response is still owed
        do_reset();
        tick(1, 0, 0, 1, 32'h40);
        tick(1, 1, 0);
        tick(1, 1, 0);
        tick(1, 0, 0);
        chk("t5_pre_valid", 32'(s_ivalid), 32'h1);
        chk("t5_pre_pc", s_ipc, 32'h40);
        do_reset();
        tick(1, 1, 1);
        chk("t5_restart_req", 32'(s_req), 32'h1);
        chk("t5_restart_addr", s_addr, 32'h0);
        repeat (8) tick(1, 1, 1);

        // 6: random stalls and redirects
        do_reset();
        p0 = n_pop;
        for (int i = 0; i < 400; i++) begin
            tick(($urandom % 4) != 0, ($urandom % 3) != 0,
                 ($urandom % 4) != 0, ($urandom % 20) == 0,
                 32'($urandom_range(0, 32'hFFFF)));
        end
        repeat (20) tick(1, 1, 1);
        chk("random_progress", 32'(n_pop - p0 > 30), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
